stream_rsp_return: RTL and testbench

- Sits directly downstream of a stream crossbar output port, between the crossbar and a single-response target (memory, peripheral).
- Gates the request handshake toward the target and records the crossbar's input index of every accepted request in an in-order tracking FIFO.
- Routes each response from the target back to the originating input port in request order.
- One instance per crossbar output.

---
 rtl/stream_rsp_return_fifo.sv | 68 ++++++
 rtl/stream_rsp_return.sv | 90 +++++++++
 tb/tb_stream_rsp_return.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_rsp_return_fifo.sv
// In-order index FIFO for stream_rsp_return.
// Holds the originating input of each outstanding request.
module stream_rsp_return_fifo #(
  parameter int unsigned Depth    = 4,
  parameter type         elem_t   = logic,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  elem_t               data_i,
  input  logic                pop_i,
  output elem_t               data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o
);

  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [CntWidth-1:0] count;
  logic                do_push;
  logic                do_pop;
  elem_t               mem [Depth];

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] next_ptr(
    input logic [PtrWidth-1:0] p
  );
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full_o  = (count == FullCnt);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  // Full and empty guard the pointers even if the caller does not.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy state; reset discards in-flight entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/stream_rsp_return.sv
// Response return path for one crossbar output port.
// Tracks request origins in order and steers responses back.
module stream_rsp_return #(
  parameter int unsigned NumInp    = 0,
  parameter int unsigned DataWidth = 1,
  parameter type         rsp_t     = logic [DataWidth-1:0],
  parameter int unsigned Depth     = 4,
  localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1,
  localparam int unsigned NumLanes = (NumInp > 0) ? NumInp : 1,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IdxWidth-1:0] req_idx_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  rsp_t                rsp_data_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  output rsp_t [NumLanes-1:0] rsp_data_o,
  output logic [NumLanes-1:0] rsp_valid_o,
  input  logic [NumLanes-1:0] rsp_ready_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                err_unexp_o
);

  typedef logic [IdxWidth-1:0] idx_inp_t;

  idx_inp_t head;
  logic     full;
  logic     empty;
  logic     push;
  logic     pop;
  logic     sel_ready;

  // A full tracker blocks the request in both directions.
  assign req_valid_o = req_valid_i & ~full;
  assign req_ready_o = req_ready_i & ~full;
  assign push        = req_valid_i & req_ready_i & ~full;

  assign rsp_ready_o = ~empty & sel_ready;
  assign pop         = rsp_valid_i & rsp_ready_o;

  stream_rsp_return_fifo #(
    .Depth  (Depth),
    .elem_t (idx_inp_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (req_idx_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  // One-hot steer of valid to the head lane, ready back from it.
  always_comb begin
    rsp_valid_o = '0;
    sel_ready   = 1'b0;
    for (int k = 0; k < NumLanes; k++) begin
      if (head == IdxWidth'(k)) begin
        rsp_valid_o[k] = rsp_valid_i & ~empty;
        sel_ready      = rsp_ready_i[k];
      end
    end
  end

  // Payload is broadcast; valid alone selects the receiver.
  always_comb begin
    rsp_data_o = '0;
    for (int k = 0; k < NumLanes; k++) begin
      rsp_data_o[k] = rsp_data_i;
    end
  end

  // Sticky flag for a response with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_unexp_o <= 1'b0;
    end else if (rsp_valid_i & empty) begin
      err_unexp_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_rsp_return.sv
// Bench for stream_rsp_return: Depth=4 and Depth=3 instances
// driven in parallel and checked against a queue model.
module tb_stream_rsp_return;

  logic            clk;
  logic            rst;
  logic [1:0]      req_idx;
  logic            req_valid;
  logic            req_ready;
  logic [7:0]      rsp_data;
  logic            rsp_valid;
  logic [3:0]      rsp_ready;

  logic            a_req_ready, a_req_valid, a_rsp_ready, a_err;
  logic [3:0][7:0] a_rsp_data;
  logic [3:0]      a_rsp_valid;
  logic [2:0]      a_out;

  logic            b_req_ready, b_req_valid, b_rsp_ready, b_err;
  logic [3:0][7:0] b_rsp_data;
  logic [3:0]      b_rsp_valid;
  logic [1:0]      b_out;

  int n_chk = 0;
  int n_err = 0;

  int q0[$];
  int q1[$];
  bit merr [2];

  stream_rsp_return #(
    .NumInp(4), .DataWidth(8), .Depth(4)
  ) u_d4 (
    .clk_i(clk), .rst_i(rst),
    .req_idx_i(req_idx), .req_valid_i(req_valid),
    .req_ready_o(a_req_ready), .req_valid_o(a_req_valid),
    .req_ready_i(req_ready),
    .rsp_data_i(rsp_data), .rsp_valid_i(rsp_valid),
    .rsp_ready_o(a_rsp_ready), .rsp_data_o(a_rsp_data),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready),
    .outstanding_o(a_out), .err_unexp_o(a_err)
  );

  stream_rsp_return #(
    .NumInp(4), .DataWidth(8), .Depth(3)
  ) u_d3 (
    .clk_i(clk), .rst_i(rst),
    .req_idx_i(req_idx), .req_valid_i(req_valid),
    .req_ready_o(b_req_ready), .req_valid_o(b_req_valid),
    .req_ready_i(req_ready),
    .rsp_data_i(rsp_data), .rsp_valid_i(rsp_valid),
    .rsp_ready_o(b_rsp_ready), .rsp_data_o(b_rsp_data),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready),
    .outstanding_o(b_out), .err_unexp_o(b_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int msize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int mhead(input int d);
    if (d == 0) return (q0.size() > 0) ? q0[0] : 0;
    return (q1.size() > 0) ? q1[0] : 0;
  endfunction

  task automatic model_check(input int d);
    int         dep, sz, hd, outs;
    bit         full, empty;
    logic       rvo, rro, sro, err;
    logic [3:0] svo;
    logic [31:0] dat;
    string      t;
    dep = (d == 0) ? 4 : 3;
    sz = msize(d);
    hd = mhead(d);
    if (d == 0) begin
      rvo = a_req_valid; rro = a_req_ready; sro = a_rsp_ready;
      svo = a_rsp_valid; outs = int'(a_out); err = a_err;
      dat = a_rsp_data;
    end else begin
      rvo = b_req_valid; rro = b_req_ready; sro = b_rsp_ready;
      svo = b_rsp_valid; outs = int'(b_out); err = b_err;
      dat = b_rsp_data;
    end
    full = (sz == dep);
    empty = (sz == 0);
    t = $sformatf("d%0d", dep);
    chk({t, " req_valid_o"}, rvo, req_valid && !full);
    chk({t, " req_ready_o"}, rro, req_ready && !full);
    chk({t, " rsp_valid_o"}, svo,
        (rsp_valid && !empty) ? (32'd1 << hd) : 32'd0);
    chk({t, " rsp_ready_o"}, sro, !empty && rsp_ready[hd]);
    chk({t, " outstanding_o"}, outs, sz);
    chk({t, " err_unexp_o"}, err, merr[d]);
    chk({t, " rsp_data_o"}, dat, {4{rsp_data}});
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int dep, sz, hd;
      bit full, empty, pop, push;
      dep = (d == 0) ? 4 : 3;
      sz = msize(d);
      hd = mhead(d);
      full = (sz == dep);
      empty = (sz == 0);
      pop = rsp_valid && !empty && rsp_ready[hd];
      push = req_valid && req_ready && !full;
      if (rst) begin
        if (d == 0) q0.delete(); else q1.delete();
        merr[d] = 1'b0;
      end else begin
        if (pop) begin
          if (d == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
        if (push) begin
          if (d == 0) q0.push_back(int'(req_idx));
          else q1.push_back(int'(req_idx));
        end
        if (rsp_valid && empty) merr[d] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_check(0);
    model_check(1);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_idx = 0; req_valid = 0; req_ready = 0;
    rsp_data = 0; rsp_valid = 0; rsp_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  typedef struct {
    logic [1:0] idx;
    logic       vi, ri;
    logic [7:0] dat;
    logic       rv;
    logic [3:0] rr;
    logic       e_rvo, e_rro;
    logic [3:0] e_svo;
    logic       e_sro;
    int         e_out;
    logic       e_err;
  } vec_t;

  vec_t tbl [7];

  initial begin
    clk = 0;
    rst = 1;
    idle();
    tbl[0] = '{2'd2, 1, 1, 8'h00, 0, 4'h0, 1, 1, 4'b0000, 0, 0, 0};
    tbl[1] = '{2'd0, 1, 1, 8'h00, 0, 4'h0, 1, 1, 4'b0000, 0, 1, 0};
    tbl[2] = '{2'd3, 1, 1, 8'h00, 0, 4'h0, 1, 1, 4'b0000, 0, 2, 0};
    tbl[3] = '{2'd0, 0, 0, 8'h0A, 1, 4'hF, 0, 0, 4'b0100, 1, 3, 0};
    tbl[4] = '{2'd0, 0, 0, 8'h0B, 1, 4'hF, 0, 0, 4'b0001, 1, 2, 0};
    tbl[5] = '{2'd0, 0, 0, 8'h0C, 1, 4'hF, 0, 0, 4'b1000, 1, 1, 0};
    tbl[6] = '{2'd0, 0, 0, 8'h00, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 0};

    // Reset for two cycles from unknown state.
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    q0.delete(); q1.delete();
    merr[0] = 0; merr[1] = 0;
    #1;
    chk("reset outstanding", a_out, 0);
    chk("reset rsp_valid_o", a_rsp_valid, 0);
    chk("reset rsp_ready_o", a_rsp_ready, 0);
    chk("reset err_unexp_o", a_err, 0);
    chk("reset d3 outstanding", b_out, 0);

    // In-order return, table driven.
    for (int i = 0; i < 7; i++) begin
      req_idx = tbl[i].idx; req_valid = tbl[i].vi;
      req_ready = tbl[i].ri; rsp_data = tbl[i].dat;
      rsp_valid = tbl[i].rv; rsp_ready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d req_valid_o", i), a_req_valid, tbl[i].e_rvo);
      chk($sformatf("tbl%0d req_ready_o", i), a_req_ready, tbl[i].e_rro);
      chk($sformatf("tbl%0d rsp_valid_o", i), a_rsp_valid, tbl[i].e_svo);
      chk($sformatf("tbl%0d rsp_ready_o", i), a_rsp_ready, tbl[i].e_sro);
      chk($sformatf("tbl%0d outstanding", i), a_out, tbl[i].e_out);
      chk($sformatf("tbl%0d err", i), a_err, tbl[i].e_err);
      for (int k = 0; k < 4; k++)
        if (tbl[i].e_svo[k])
          chk($sformatf("tbl%0d lane%0d data", i, k),
              a_rsp_data[k], tbl[i].dat);
      cycle();
    end

    // Full stall, then pop-only, then accept.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_idx = 2'(i); req_valid = 1; req_ready = 1;
      cycle();
    end
    #1;
    chk("full outstanding", a_out, 4);
    chk("full req_ready_o", a_req_ready, 0);
    chk("full req_valid_o", a_req_valid, 0);
    req_idx = 2'd1; rsp_valid = 1; rsp_ready = 4'hF;
    cycle();
    chk("full pop only", a_out, 3);
    rsp_valid = 0;
    cycle();
    chk("full accept after", a_out, 4);

    // Backpressure on head lane 1.
    do_reset();
    req_idx = 2'd1; req_valid = 1; req_ready = 1;
    cycle();
    idle();
    rsp_valid = 1; rsp_ready = 4'b1101; rsp_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp rsp_ready_o", a_rsp_ready, 0);
      chk("bp rsp_valid_o", a_rsp_valid, 4'b0010);
      cycle();
    end
    rsp_ready = 4'hF;
    chk("bp before pop", a_out, 1);
    cycle();
    chk("bp after pop", a_out, 0);

    // Pointer wrap on the Depth=3 instance.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      req_idx = 2'(i % 4); req_valid = 1; req_ready = 1;
      cycle();
      idle();
      rsp_valid = 1; rsp_ready = 4'hF; rsp_data = 8'(i);
      #1;
      chk($sformatf("wrap%0d rsp_valid_o", i), b_rsp_valid,
          32'd1 << (i % 4));
      chk($sformatf("wrap%0d max outstanding", i),
          (int'(b_out) <= 3), 1);
      cycle();
    end

    // Unexpected response, then reset over push and pop.
    do_reset();
    rsp_valid = 1; rsp_ready = 4'hF;
    #1;
    chk("unexp rsp_ready_o", a_rsp_ready, 0);
    cycle();
    chk("unexp err set", a_err, 1);
    idle();
    cycle();
    cycle();
    chk("unexp err sticky", a_err, 1);
    req_idx = 2'd3; req_valid = 1; req_ready = 1;
    cycle();
    cycle();
    chk("two outstanding", a_out, 2);
    rst = 1; rsp_valid = 1; rsp_ready = 4'hF;
    cycle();
    rst = 0;
    idle();
    chk("rst mid outstanding", a_out, 0);
    chk("rst mid err", a_err, 0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      req_idx = 2'($urandom_range(0, 3));
      req_valid = 1'($urandom);
      req_ready = 1'($urandom);
      rsp_data = 8'($urandom);
      rsp_valid = 1'($urandom);
      rsp_ready = 4'($urandom);
      cycle();
    end
    rst = 0;
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
